// File: rtl/seq_det_word_ctrl.sv
// Word-level controller for an external 1010 Moore detector (optional SEQ_DET_LSB_FIRST_EN: LSB-first shift).
// Latency: result valid WIDTH+3 cycles after the input handshake.
// Backpressure: in_ready only in IDLE; result held stable in REPORT until out_ready.
module seq_det_word_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_rst_n,
  output logic             det_bit,
  input  logic             det_hit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_any,
  output logic [POS_W-1:0] out_first_pos,
  output logic             busy
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    REPORT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [POS_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic [POS_W-1:0] first_pos;
  logic             found;
  logic             head_bit;
  logic             hit_take;
  logic [POS_W-1:0] hit_pos;

`ifdef SEQ_DET_LSB_FIRST_EN
  assign head_bit = shreg[0];
`else
  assign head_bit = shreg[WIDTH-1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    det_bit   = 1'b0;
    busy      = 1'b1;
    hit_take  = 1'b0;
    hit_pos   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = CLR;
        end
      end
      CLR: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        det_bit = head_bit;
        // Moore output lags one cycle: a hit now belongs to the previous bit.
        hit_take = det_hit && (idx != '0);
        hit_pos  = idx - POS_W'(1);
        if (idx == LAST_IDX) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        hit_take  = det_hit;
        hit_pos   = LAST_IDX;
        state_nxt = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      idx       <= '0;
      count     <= '0;
      first_pos <= '0;
      found     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg     <= in_data;
            idx       <= '0;
            count     <= '0;
            first_pos <= '0;
            found     <= 1'b0;
          end
        end
        SHIFT: begin
`ifdef SEQ_DET_LSB_FIRST_EN
          shreg <= shreg >> 1;
`else
          shreg <= shreg << 1;
`endif
          if (idx != LAST_IDX) begin
            idx <= idx + POS_W'(1);
          end
        end
        default: begin
        end
      endcase

      if (hit_take) begin
        if (count != '1) begin
          count <= count + CNT_W'(1);
        end
        if (!found) begin
          found     <= 1'b1;
          first_pos <= hit_pos;
        end
      end
    end
  end

  // Detector is held in reset by the controller reset as well as the CLR cycle.
  assign det_rst_n     = !reset && (state != CLR);
  assign out_count     = count;
  assign out_any       = |count;
  assign out_first_pos = first_pos;

endmodule

// File: tb/tb_seq_det_word_ctrl.sv
// Bench for seq_det_word_ctrl: models the external 1010 detector and checks results against a pattern-scan reference.
module tb_seq_det_word_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int POS_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             det_rst_n;
  logic             det_bit;
  logic             det_hit;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_count;
  logic             out_any;
  logic [POS_W-1:0] out_first_pos;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rst_low_cnt = 0;
  logic inj = 1'b0;

  seq_det_word_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .det_rst_n(det_rst_n), .det_bit(det_bit), .det_hit(det_hit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_any(out_any), .out_first_pos(out_first_pos),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!reset && !det_rst_n) rst_low_cnt <= rst_low_cnt + 1;

  // External detector: length of the 1010 prefix matched so far, 4 = hit (Moore).
  logic [2:0] plen;
  always @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) plen <= 3'd0;
    else begin
      case (plen)
        3'd0: plen <= det_bit ? 3'd1 : 3'd0;
        3'd1: plen <= det_bit ? 3'd1 : 3'd2;
        3'd2: plen <= det_bit ? 3'd3 : 3'd0;
        3'd3: plen <= det_bit ? 3'd1 : 3'd4;
        default: plen <= det_bit ? 3'd1 : 3'd0;
      endcase
    end
  end
  assign det_hit = (plen == 3'd4) || inj;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: leftmost non-overlapping occurrences of 1010 in shift order.
  function automatic void ref_scan(input logic [WIDTH-1:0] w, output int cnt, output int pos);
    int b[WIDTH];
    int j;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef SEQ_DET_LSB_FIRST_EN
      b[i] = int'(w[i]);
`else
      b[i] = int'(w[WIDTH-1-i]);
`endif
    end
    cnt = 0;
    pos = 0;
    j = 0;
    while (j + 3 < WIDTH) begin
      if (b[j] == 1 && b[j+1] == 0 && b[j+2] == 1 && b[j+3] == 0) begin
        if (cnt == 0) pos = j + 3;
        cnt++;
        j += 4;
      end else begin
        j++;
      end
    end
    if (cnt > (1 << CNT_W) - 1) cnt = (1 << CNT_W) - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int hold, input bit inject_first);
    int ec, ep, t0, waitc, r0;
    ref_scan(w, ec, ep);
    r0 = rst_low_cnt;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      step();
      waitc++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    t0 = cyc;
    step();
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_after_accept", in_ready, 0);
    if (inject_first) begin
      step();
      inj = 1'b1;
      step();
      inj = 1'b0;
    end
    waitc = 0;
    while (!out_valid && waitc < 60) begin
      step();
      waitc++;
    end
    chk("out_valid_wait", out_valid, 1);
    chk("latency", cyc - t0, WIDTH + 3);
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid_hold", out_valid, 1);
      chk("out_count", out_count, ec);
      chk("out_any", out_any, ec != 0);
      chk("out_first_pos", out_first_pos, ep);
      chk("in_ready_report", in_ready, 0);
      if (h < hold) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom);
        in_data   = WIDTH'($urandom);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      step();
    end
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_idle", in_ready, 1);
    chk("det_rst_n_low_cycles", rst_low_cnt - r0, 1);
  endtask

  initial begin
    bit ov_seen;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_det_rst_n", det_rst_n, 0);
    chk("rst_det_bit", det_bit, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_first_pos", out_first_pos, 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_det_rst_n", det_rst_n, 1);

    send_word(8'b1010_1010, 0, 1'b0);
    send_word(8'b1011_0100, 1, 1'b0);
    send_word(8'h00, 0, 1'b0);
    send_word(8'b0101_0000, 0, 1'b0);
    send_word(8'b0000_0101, 2, 1'b0);
    send_word(8'b1010_1010, 5, 1'b0);
    send_word(8'h00, 0, 1'b1);
    send_word(8'hFF, 0, 1'b0);

    // Reset during SHIFT at bit index 4.
    in_valid = 1'b1;
    in_data  = 8'b1010_1010;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("mid_busy_before_reset", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_det_rst_n", det_rst_n, 0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_post_in_ready", in_ready, 1);
    chk("mid_post_busy", busy, 0);
    ov_seen = 1'b0;
    repeat (15) begin
      step();
      if (out_valid) ov_seen = 1'b1;
    end
    chk("mid_no_output", ov_seen, 0);
    send_word(8'b1010_1010, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      send_word(WIDTH'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
